jar_sram_stream: RTL and testbench

Parametrised successor to the 8-byte TT02 scratch SRAM. It holds `DEPTH` words of `DW` bits behind a narrow nibble-serial bus, with an explicit opcode port, a persistent word pointer, and auto-increment read/write for burst streaming. A multi-cycle CLEAR sweep zeroes the array. A sticky error flag reports bad pointer loads. It sits directly behind the tile's pin mux; the pin mux maps `io_in`/`io_out` onto these ports.

---
 rtl/jar_sram_stream.sv | 120 ++++++++++++
 tb/tb_jar_sram_stream.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/jar_sram_stream.sv
// Nibble-serial scratch SRAM: DEPTH x DW words, persistent pointer with auto-increment,
// multi-cycle CLEAR sweep and a sticky bad-pointer flag.
module jar_sram_stream #(
  parameter int DW    = 8,
  parameter int NW    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [2:0]    i_op,
  input  logic [NW-1:0] i_din,
  input  logic          i_oe,
  output logic [DW-1:0] o_dout,
  output logic          o_busy,
  output logic          o_err,
  output logic [AW-1:0] o_ptr
);

  // state | meaning
  // IDLE  | opcodes accepted; SWEEP | zeroing mem[clr_idx], opcodes ignored
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [2:0] OP_SHIFT     = 3'd1;
  localparam logic [2:0] OP_SETPTR    = 3'd2;
  localparam logic [2:0] OP_WRITE     = 3'd3;
  localparam logic [2:0] OP_WRITE_INC = 3'd4;
  localparam logic [2:0] OP_READ      = 3'd5;
  localparam logic [2:0] OP_READ_INC  = 3'd6;
  localparam logic [2:0] OP_CLEAR     = 3'd7;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_data_tmp;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_clr_idx;
  logic          r_err;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [AW-1:0] w_ptr_inc;
  logic          w_ptr_ok;

  assign w_accept  = (r_state == IDLE) && !i_rst;
  // Increment wraps at DEPTH, which need not be a power of two
  assign w_ptr_inc = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  assign w_ptr_ok  = {1'b0, r_data_tmp[AW-1:0]} < DEPTH_W;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_op == OP_CLEAR) w_state_nxt = SWEEP;
      SWEEP:   if (r_clr_idx == LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_ptr;
    w_mem_wdata = r_data_tmp;
    if (r_state == SWEEP) begin
      w_mem_we    = !i_rst;
      w_mem_addr  = r_clr_idx;
      w_mem_wdata = '0;
    end else if (i_op == OP_WRITE || i_op == OP_WRITE_INC) begin
      w_mem_we    = !i_rst;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_clr_idx <= '0;
    else if (r_state == SWEEP)      r_clr_idx <= (r_clr_idx == LAST) ? r_clr_idx : r_clr_idx + 1'b1;
    else if (i_op == OP_CLEAR)      r_clr_idx <= '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_tmp <= '0;
      r_ptr      <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      case (i_op)
        OP_SHIFT:     r_data_tmp <= {i_din, r_data_tmp[DW-1:NW]};
        OP_SETPTR: begin
          if (w_ptr_ok) r_ptr <= r_data_tmp[AW-1:0];
          else          r_err <= 1'b1;
        end
        OP_WRITE_INC: r_ptr <= w_ptr_inc;
        OP_READ:      r_data_tmp <= r_mem[r_ptr];
        OP_READ_INC: begin
          r_data_tmp <= r_mem[r_ptr];
          r_ptr      <= w_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign o_dout = i_oe ? r_data_tmp : '0;
  assign o_busy = (r_state == SWEEP);
  assign o_err  = r_err;
  assign o_ptr  = r_ptr;

endmodule

// File: tb/tb_jar_sram_stream.sv
// Directed bench for jar_sram_stream: default build (DEPTH=16) and a DEPTH=5 build side by side.
module tb_jar_sram_stream;

  localparam logic [2:0] NOP = 3'd0, SHIFT = 3'd1, SETPTR = 3'd2, WRITE = 3'd3,
                         WRITE_INC = 3'd4, READ = 3'd5, READ_INC = 3'd6, CLEAR = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op_a, op_b;
  logic [3:0] din_a, din_b;
  logic       oe_a, oe_b;
  logic [7:0] dout_a, dout_b;
  logic       busy_a, busy_b, err_a, err_b;
  logic [3:0] ptr_a;
  logic [2:0] ptr_b;

  int errors = 0;
  int checks = 0;
  logic [7:0] expq [$];

  jar_sram_stream u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_op(op_a), .i_din(din_a), .i_oe(oe_a),
    .o_dout(dout_a), .o_busy(busy_a), .o_err(err_a), .o_ptr(ptr_a)
  );

  jar_sram_stream #(.DEPTH(5)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_op(op_b), .i_din(din_b), .i_oe(oe_b),
    .o_dout(dout_b), .o_busy(busy_b), .o_err(err_b), .o_ptr(ptr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one opcode to one instance for one edge; outputs are settled at the following negedge
  task automatic step(input bit b, input logic [2:0] op, input logic [3:0] d);
    if (b) begin op_b = op; din_b = d; end
    else   begin op_a = op; din_a = d; end
    @(posedge clk);
    @(negedge clk);
    op_a = NOP;
    op_b = NOP;
  endtask

  task automatic load(input bit b, input logic [7:0] v);
    step(b, SHIFT, v[3:0]);
    step(b, SHIFT, v[7:4]);
  endtask

  task automatic rd(input bit b, input logic [2:0] op, input logic [7:0] exp, input string tag);
    expq.push_back(exp);
    step(b, op, 4'h0);
    chk(tag, b ? dout_b : dout_a, expq.pop_front());
  endtask

  initial begin
    int cnt;
    rst = 1'b1; op_a = SHIFT; op_b = SHIFT; din_a = 4'hF; din_b = 4'hF; oe_a = 1'b1; oe_b = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0; op_a = NOP; op_b = NOP;
    chk("rst_dout", dout_a, 8'h00);
    chk("rst_ptr", ptr_a, 4'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_dout_b", dout_b, 8'h00);

    step(0, SHIFT, 4'h5);
    step(0, SHIFT, 4'hA);
    chk("shift_a5", dout_a, 8'hA5);
    oe_a = 1'b0; #1;
    chk("oe_gate", dout_a, 8'h00);
    oe_a = 1'b1; #1;
    step(0, WRITE, 4'h0);
    load(0, 8'h03);
    step(0, SETPTR, 4'h0);
    chk("setptr3", ptr_a, 4'd3);
    load(0, 8'h00);
    step(0, SETPTR, 4'h0);
    chk("setptr0", ptr_a, 4'd0);
    rd(0, READ, 8'hA5, "read_a5");
    load(0, 8'h6B);
    step(0, WRITE, 4'h0);
    load(0, 8'h00);
    rd(0, READ, 8'h6B, "wr_then_rd");

    load(1, 8'h03);
    step(1, SETPTR, 4'h0);
    chk("b_setptr3", ptr_b, 3'd3);
    load(1, 8'h11); step(1, WRITE_INC, 4'h0);
    load(1, 8'h22); step(1, WRITE_INC, 4'h0);
    load(1, 8'h33); step(1, WRITE_INC, 4'h0);
    chk("b_wrap_ptr", ptr_b, 3'd1);
    load(1, 8'h03);
    step(1, SETPTR, 4'h0);
    rd(1, READ_INC, 8'h11, "b_rdinc0");
    rd(1, READ_INC, 8'h22, "b_rdinc1");
    rd(1, READ_INC, 8'h33, "b_rdinc2");
    chk("b_rdinc_ptr", ptr_b, 3'd1);

    load(1, 8'h05);
    step(1, SETPTR, 4'h0);
    chk("b_bad5_ptr", ptr_b, 3'd1);
    chk("b_bad5_err", err_b, 1'b1);
    load(1, 8'h07);
    step(1, SETPTR, 4'h0);
    chk("b_bad7_ptr", ptr_b, 3'd1);
    load(1, 8'h02);
    step(1, SETPTR, 4'h0);
    chk("b_ok_ptr", ptr_b, 3'd2);
    chk("b_err_sticky", err_b, 1'b1);
    chk("a_err_clean", err_a, 1'b0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("b_err_rst", err_b, 1'b0);

    load(0, 8'hFF);
    repeat (16) step(0, WRITE_INC, 4'h0);
    load(0, 8'h07);
    step(0, SETPTR, 4'h0);
    load(0, 8'h3C);
    step(0, CLEAR, 4'h0);
    chk("clr_busy_on", busy_a, 1'b1);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      step(0, (cnt == 2) ? READ : (cnt == 3) ? CLEAR : (cnt == 4) ? SETPTR : NOP, 4'h0);
      cnt++;
    end
    chk("clr_busy_cycles", cnt, 16);
    chk("clr_rd_ignored", dout_a, 8'h3C);
    chk("clr_ptr_kept", ptr_a, 4'd7);
    for (int i = 0; i < 16; i++) rd(0, READ_INC, 8'h00, "clr_zero");
    chk("clr_ptr_after", ptr_a, 4'd7);

    load(0, 8'hFF);
    repeat (16) step(0, WRITE_INC, 4'h0);
    step(0, CLEAR, 4'h0);
    repeat (6) step(0, NOP, 4'h0);
    rst = 1'b1;
    step(0, NOP, 4'h0);
    rst = 1'b0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_ptr", ptr_a, 4'd0);
    for (int i = 0; i < 16; i++) rd(0, READ_INC, (i < 6) ? 8'h00 : 8'hFF, "abort_word");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
